// File: rtl/id_ex_ctrl_stage.sv
// ID/EX stage: main-control decode of the IF/ID instruction and the ID/EX pipeline register,
// with hazard-unit stall/flush and a saturating count of bubbles loaded.
module id_ex_ctrl_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       if_id_instr,
  input  logic [DATA_W-1:0] if_id_npc,
  input  logic              if_id_valid,
  input  logic [DATA_W-1:0] rd_data1,
  input  logic [DATA_W-1:0] rd_data2,
  input  logic              stall,
  input  logic              flush,
  output logic              ex_valid,
  output logic              ex_regwrite,
  output logic              ex_memtoreg,
  output logic              ex_branch,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_regdst,
  output logic              ex_alusrc,
  output logic [1:0]        ex_aluop,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_npc,
  output logic [DATA_W-1:0] ex_rd_data1,
  output logic [DATA_W-1:0] ex_rd_data2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic              ex_illegal,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regdst;
    logic       alusrc;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [5:0]               opcode_p0;
  ctrl_t                    ctrl_p0;
  logic signed [15:0]       imm16_p0;
  logic signed [DATA_W-1:0] imm_ext_p0;
  logic                     load_bubble_p0;
  logic                     load_instr_p0;

  assign opcode_p0  = if_id_instr[31:26];
  assign imm16_p0   = if_id_instr[15:0];
  assign imm_ext_p0 = DATA_W'(imm16_p0);

  assign load_bubble_p0 = flush | (~stall & ~if_id_valid);
  assign load_instr_p0  = ~flush & ~stall & if_id_valid;

  always_comb begin
    ctrl_p0 = '0;
    case (opcode_p0)
      OP_RTYPE: begin
        ctrl_p0.regdst   = 1'b1;
        ctrl_p0.regwrite = 1'b1;
        ctrl_p0.aluop    = 2'b10;
      end
      OP_LW: begin
        ctrl_p0.alusrc   = 1'b1;
        ctrl_p0.memtoreg = 1'b1;
        ctrl_p0.regwrite = 1'b1;
        ctrl_p0.memread  = 1'b1;
        ctrl_p0.aluop    = 2'b00;
      end
      OP_SW: begin
        ctrl_p0.alusrc   = 1'b1;
        ctrl_p0.memwrite = 1'b1;
        ctrl_p0.aluop    = 2'b00;
      end
      OP_BEQ: begin
        ctrl_p0.branch   = 1'b1;
        ctrl_p0.aluop    = 2'b01;
      end
      default: begin
        ctrl_p0.aluop    = 2'b11;
        ctrl_p0.illegal  = 1'b1;
      end
    endcase
  end

  // ---- ID -> EX boundary ----
  logic                     vld_p1;
  ctrl_t                    ctrl_p1;
  logic [5:0]               funct_p1;
  logic [DATA_W-1:0]        npc_p1;
  logic [DATA_W-1:0]        rd_data1_p1;
  logic [DATA_W-1:0]        rd_data2_p1;
  logic signed [DATA_W-1:0] imm_p1;
  logic [4:0]               rt_p1;
  logic [4:0]               rd_p1;
  logic [CNT_W-1:0]         bubble_cnt_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      ctrl_p1       <= '0;
      funct_p1      <= '0;
      npc_p1        <= '0;
      rd_data1_p1   <= '0;
      rd_data2_p1   <= '0;
      imm_p1        <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      bubble_cnt_p1 <= '0;
    end else if (load_bubble_p0) begin
      vld_p1        <= 1'b0;
      ctrl_p1       <= '0;
      funct_p1      <= '0;
      npc_p1        <= '0;
      rd_data1_p1   <= '0;
      rd_data2_p1   <= '0;
      imm_p1        <= '0;
      rt_p1         <= '0;
      rd_p1         <= '0;
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else if (load_instr_p0) begin
      vld_p1        <= 1'b1;
      ctrl_p1       <= ctrl_p0;
      funct_p1      <= if_id_instr[5:0];
      npc_p1        <= if_id_npc;
      rd_data1_p1   <= rd_data1;
      rd_data2_p1   <= rd_data2;
      imm_p1        <= imm_ext_p0;
      rt_p1         <= if_id_instr[20:16];
      rd_p1         <= if_id_instr[15:11];
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_regwrite = ctrl_p1.regwrite;
  assign ex_memtoreg = ctrl_p1.memtoreg;
  assign ex_branch   = ctrl_p1.branch;
  assign ex_memread  = ctrl_p1.memread;
  assign ex_memwrite = ctrl_p1.memwrite;
  assign ex_regdst   = ctrl_p1.regdst;
  assign ex_alusrc   = ctrl_p1.alusrc;
  assign ex_aluop    = ctrl_p1.aluop;
  assign ex_illegal  = ctrl_p1.illegal;
  assign ex_funct    = funct_p1;
  assign ex_npc      = npc_p1;
  assign ex_rd_data1 = rd_data1_p1;
  assign ex_rd_data2 = rd_data2_p1;
  assign ex_imm      = imm_p1;
  assign ex_rt       = rt_p1;
  assign ex_rd       = rd_p1;
  assign bubble_cnt  = bubble_cnt_p1;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed bench for id_ex_ctrl_stage: decode, field capture, stall/flush, async reset and
// bubble-counter saturation (second instance with CNT_W=2).
module tb_id_ex_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        if_id_valid;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        stall;
  logic        flush;

  logic        ex_valid, ex_regwrite, ex_memtoreg, ex_branch, ex_memread, ex_memwrite;
  logic        ex_regdst, ex_alusrc, ex_illegal;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_funct;
  logic [31:0] ex_npc, ex_rd_data1, ex_rd_data2, ex_imm;
  logic [4:0]  ex_rt, ex_rd;
  logic [15:0] bubble_cnt;

  logic        v2, rw2, m2r2, br2, mr2, mw2, rdst2, asrc2, ill2;
  logic [1:0]  aop2;
  logic [5:0]  fn2;
  logic [31:0] npc2, d1_2, d2_2, imm2;
  logic [4:0]  rt2, rd2;
  logic [1:0]  bubble_cnt2;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  id_ex_ctrl_stage #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .if_id_valid(if_id_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .stall(stall), .flush(flush), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_branch(ex_branch), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc),
    .ex_aluop(ex_aluop), .ex_funct(ex_funct), .ex_npc(ex_npc),
    .ex_rd_data1(ex_rd_data1), .ex_rd_data2(ex_rd_data2), .ex_imm(ex_imm),
    .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_illegal(ex_illegal), .bubble_cnt(bubble_cnt)
  );

  id_ex_ctrl_stage #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_id_instr(if_id_instr), .if_id_npc(if_id_npc),
    .if_id_valid(if_id_valid), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .stall(stall), .flush(flush), .ex_valid(v2), .ex_regwrite(rw2),
    .ex_memtoreg(m2r2), .ex_branch(br2), .ex_memread(mr2),
    .ex_memwrite(mw2), .ex_regdst(rdst2), .ex_alusrc(asrc2),
    .ex_aluop(aop2), .ex_funct(fn2), .ex_npc(npc2),
    .ex_rd_data1(d1_2), .ex_rd_data2(d2_2), .ex_imm(imm2),
    .ex_rt(rt2), .ex_rd(rd2), .ex_illegal(ill2), .bubble_cnt(bubble_cnt2)
  );

  // {valid, regwrite, memtoreg, branch, memread, memwrite, regdst, alusrc, aluop[1:0], illegal}
  logic [10:0] ctl;
  assign ctl = {ex_valid, ex_regwrite, ex_memtoreg, ex_branch, ex_memread, ex_memwrite,
                ex_regdst, ex_alusrc, ex_aluop, ex_illegal};

  logic [170:0] all_out;
  assign all_out = {ctl, ex_funct, ex_npc, ex_rd_data1, ex_rd_data2, ex_imm, ex_rt, ex_rd,
                    bubble_cnt};

  localparam logic [10:0] C_ADD = 11'b1_1_0_0_0_0_1_0_10_0;
  localparam logic [10:0] C_LW  = 11'b1_1_1_0_1_0_0_1_00_0;
  localparam logic [10:0] C_SW  = 11'b1_0_0_0_0_1_0_1_00_0;
  localparam logic [10:0] C_BEQ = 11'b1_0_0_1_0_0_0_0_01_0;
  localparam logic [10:0] C_ILL = 11'b1_0_0_0_0_0_0_0_11_1;
  localparam logic [10:0] C_BUB = 11'b0_0_0_0_0_0_0_0_00_0;

  localparam logic [31:0] I_ADD  = 32'h0085_1020;
  localparam logic [31:0] I_LW   = 32'h8C82_0004;
  localparam logic [31:0] I_SW   = 32'hAC82_0004;
  localparam logic [31:0] I_BEQ  = 32'h1085_0003;
  localparam logic [31:0] I_BEQN = 32'h1085_FFFF;
  localparam logic [31:0] I_ILL  = 32'hFC00_0000;

  task automatic cyc(input logic [31:0] ins, input logic [31:0] npc,
                     input logic v, input logic st, input logic fl);
    if_id_instr = ins;
    if_id_npc   = npc;
    rd_data1    = npc ^ 32'hA5A5_0000;
    rd_data2    = ~npc;
    if_id_valid = v;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    #1;
    if (fl || (!st && !v))
      exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cyc(I_ADD, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    cyc(I_ADD, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    checks++;
    if (all_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs actual=%h required=0", all_out);
    end
    checks++;
    if (bubble_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL reset_cnt2 actual=%0d required=0", bubble_cnt2);
    end
    rst_n = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_add;
    cyc(I_ADD, 32'h0000_0104, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_ADD) begin
      failures++;
      $display("FAIL add_ctl actual=%b required=%b", ctl, C_ADD);
    end
    checks++;
    if ({ex_funct, ex_rd, ex_rt} !== {6'b100000, 5'd2, 5'd5}) begin
      failures++;
      $display("FAIL add_fields actual funct=%b rd=%0d rt=%0d required 100000/2/5",
               ex_funct, ex_rd, ex_rt);
    end
    checks++;
    if ({ex_npc, ex_rd_data1, ex_rd_data2, ex_imm} !==
        {32'h0000_0104, 32'hA5A5_0104, 32'hFFFF_FEFB, 32'h0000_1020}) begin
      failures++;
      $display("FAIL add_data actual npc=%h d1=%h d2=%h imm=%h required 104/a5a50104/fffffefb/1020",
               ex_npc, ex_rd_data1, ex_rd_data2, ex_imm);
    end
  endtask

  task automatic test_mem_branch;
    cyc(I_LW, 32'h0000_0108, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_LW || ex_imm !== 32'd4 || ex_rt !== 5'd2) begin
      failures++;
      $display("FAIL lw actual ctl=%b imm=%h rt=%0d required ctl=%b imm=4 rt=2",
               ctl, ex_imm, ex_rt, C_LW);
    end
    cyc(I_SW, 32'h0000_010C, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_SW) begin
      failures++;
      $display("FAIL sw_ctl actual=%b required=%b", ctl, C_SW);
    end
    cyc(I_BEQ, 32'h0000_0110, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_BEQ || ex_imm !== 32'd3) begin
      failures++;
      $display("FAIL beq actual ctl=%b imm=%h required ctl=%b imm=3", ctl, ex_imm, C_BEQ);
    end
    cyc(I_BEQN, 32'h0000_0114, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ex_imm !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL beq_signext actual=%h required=ffffffff", ex_imm);
    end
  endtask

  task automatic test_illegal;
    cyc(I_ILL, 32'h0000_0118, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_ILL) begin
      failures++;
      $display("FAIL illegal_ctl actual=%b required=%b", ctl, C_ILL);
    end
    cyc(I_ILL, 32'h0000_011C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctl !== C_BUB || ex_npc !== 32'd0) begin
      failures++;
      $display("FAIL illegal_invalid actual ctl=%b npc=%h required ctl=0 npc=0", ctl, ex_npc);
    end
    checks++;
    if (bubble_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL invalid_bubble_cnt actual=%0d required=%0d", bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_stall_flush;
    cyc(I_ADD, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc((i == 1) ? I_SW : I_LW, 32'h0000_0300 + 32'(i), (i != 2), 1'b1, 1'b0);
      checks++;
      if (ctl !== C_ADD || ex_npc !== 32'h0000_0200 || ex_rd_data2 !== 32'hFFFF_FDFF ||
          bubble_cnt !== exp_cnt) begin
        failures++;
        $display("FAIL stall_hold[%0d] actual ctl=%b npc=%h d2=%h cnt=%0d required ctl=%b npc=200 d2=fffffdff cnt=%0d",
                 i, ctl, ex_npc, ex_rd_data2, bubble_cnt, C_ADD, exp_cnt);
      end
    end
    cyc(I_LW, 32'h0000_0400, 1'b1, 1'b1, 1'b1);
    checks++;
    if (ctl !== C_BUB || ex_npc !== 32'd0 || ex_imm !== 32'd0 || ex_rt !== 5'd0) begin
      failures++;
      $display("FAIL stall_flush_bubble actual ctl=%b npc=%h imm=%h rt=%0d required all 0",
               ctl, ex_npc, ex_imm, ex_rt);
    end
    checks++;
    if (bubble_cnt !== exp_cnt) begin
      failures++;
      $display("FAIL stall_flush_cnt actual=%0d required=%0d", bubble_cnt, exp_cnt);
    end
  endtask

  task automatic test_async_reset;
    cyc(I_LW, 32'h0000_0500, 1'b1, 1'b1, 1'b0);
    cyc(I_LW, 32'h0000_0504, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_out !== '0 || bubble_cnt2 !== 2'd0) begin
      failures++;
      $display("FAIL async_reset actual=%h cnt2=%0d required=0", all_out, bubble_cnt2);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_cnt = 16'd0;
  endtask

  task automatic test_saturation;
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 5; i++) begin
      cyc(I_ADD, 32'h0000_0600, 1'b1, 1'b0, 1'b1);
      checks++;
      if (bubble_cnt2 !== sat_exp[i] || bubble_cnt !== exp_cnt || ex_valid !== 1'b0) begin
        failures++;
        $display("FAIL sat_cnt[%0d] actual cnt2=%0d cnt=%0d valid=%b required cnt2=%0d cnt=%0d valid=0",
                 i, bubble_cnt2, bubble_cnt, ex_valid, sat_exp[i], exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mem_branch();
    test_illegal();
    test_stall_flush();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
